// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the 16-bit, 5-stage pipelined CPU.
//
// Decodes the IF/ID instruction word into control signals, register
// specifiers, a sign-extended immediate and two register operands. It also
// holds the architectural register file, which the WB stage writes.
//
// Optional build macro:
//   REG_BYPASS_EN - a read of the register being written in the same cycle
//                   returns i_wrData combinationally. When undefined, the
//                   read returns the stored (old) value until after the edge.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_hlt                   processor halted (blocks register writes)
//   i_instr, i_pc           instruction word and its PC
//   i_wrReg/i_wrData/i_wrEn WB write port
//   i_Z                     zero flag from EX (conditions ADDZ)
//   o_port0, o_port1        register operands
//   o_sext                  sign-extended immediate
//   o_instr                 instruction passthrough
//   o_wrReg, o_wrRegEn      destination register and its enable
//   o_memRd, o_memWr        LW / SW
//   o_aluOp, o_aluSrc       ALU operation, ALU B operand select
//   o_mem2reg               writeback selects memory data
//   o_sawBr, o_sawJ         branch / jump seen
//   o_shAmt                 shift amount
//   o_rdReg1, o_rdReg2      read register numbers
//   o_rdReg1En, o_rdReg2En  read ports are real sources (hazard unit)
//   o_hlt                   HLT instruction
module id_stage #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_hlt,
   input  logic [15:0]       i_instr,
   input  logic [15:0]       i_pc,
   input  logic [3:0]        i_wrReg,
   input  logic [DATA_W-1:0] i_wrData,
   input  logic              i_wrEn,
   input  logic              i_Z,
   output logic [DATA_W-1:0] o_port0,
   output logic [DATA_W-1:0] o_port1,
   output logic [DATA_W-1:0] o_sext,
   output logic [15:0]       o_instr,
   output logic [3:0]        o_wrReg,
   output logic              o_memRd,
   output logic              o_memWr,
   output logic [3:0]        o_aluOp,
   output logic              o_mem2reg,
   output logic              o_sawBr,
   output logic              o_sawJ,
   output logic              o_aluSrc,
   output logic [3:0]        o_shAmt,
   output logic [3:0]        o_rdReg1,
   output logic [3:0]        o_rdReg2,
   output logic              o_hlt,
   output logic              o_wrRegEn,
   output logic              o_rdReg1En,
   output logic              o_rdReg2En
);

   localparam logic [3:0] OP_ADDZ = 4'h1;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_NOR  = 4'h4;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_LHB  = 4'hA;
   localparam logic [3:0] OP_LLB  = 4'hB;
   localparam logic [3:0] OP_B    = 4'hC;
   localparam logic [3:0] OP_JAL  = 4'hD;
   localparam logic [3:0] OP_JR   = 4'hE;
   localparam logic [3:0] OP_HLT  = 4'hF;

   logic [3:0] w_op, w_rd, w_rs, w_rt;
   logic       w_wrQual;
   logic       w_wrCand;

   logic [DATA_W-1:0] r_regs [NREG];

   assign w_op = i_instr[15:12];
   assign w_rd = i_instr[11:8];
   assign w_rs = i_instr[7:4];
   assign w_rt = i_instr[3:0];

   // i_pc is carried alongside the instruction but not needed for decode.
   logic w_pcUnused;
   assign w_pcUnused = ^i_pc;

   assign o_instr   = i_instr;
   assign o_shAmt   = w_rt;
   assign o_memRd   = (w_op == OP_LW);
   assign o_memWr   = (w_op == OP_SW);
   assign o_mem2reg = (w_op == OP_LW);
   assign o_sawBr   = (w_op == OP_B);
   assign o_sawJ    = (w_op == OP_JAL) || (w_op == OP_JR);
   assign o_hlt     = (w_op == OP_HLT);
   assign o_aluSrc  = (w_op == OP_LW) || (w_op == OP_SW) ||
                      (w_op == OP_LHB) || (w_op == OP_LLB);

   // WB write that will actually land at the next edge (ignoring reset,
   // which also forces the operands to zero).
   assign w_wrQual = i_wrEn & ~i_hlt & (i_wrReg != 4'd0);

   always_comb begin
      o_aluOp    = 4'd0;
      o_sext     = '0;
      o_rdReg1   = 4'd0;
      o_rdReg1En = 1'b0;
      o_rdReg2   = 4'd0;
      o_rdReg2En = 1'b0;
      o_wrReg    = 4'd0;
      w_wrCand   = 1'b0;

      if (w_op <= OP_SRA) begin
         o_aluOp    = w_op;
         o_rdReg1   = w_rs;
         o_rdReg1En = 1'b1;
         o_wrReg    = w_rd;
         // ADDZ only commits its result when the zero flag is set.
         w_wrCand   = (w_op != OP_ADDZ) | i_Z;
         if (w_op <= OP_NOR) begin
            o_rdReg2   = w_rt;
            o_rdReg2En = 1'b1;
         end
      end else begin
         case (w_op)
            OP_LW: begin
               o_sext     = {{(DATA_W-4){i_instr[3]}}, i_instr[3:0]};
               o_rdReg1   = w_rs;
               o_rdReg1En = 1'b1;
               o_wrReg    = w_rd;
               w_wrCand   = 1'b1;
            end
            OP_SW: begin
               o_sext     = {{(DATA_W-4){i_instr[3]}}, i_instr[3:0]};
               o_rdReg1   = w_rs;
               o_rdReg1En = 1'b1;
               // Store data comes from rd on port 1.
               o_rdReg2   = w_rd;
               o_rdReg2En = 1'b1;
            end
            OP_LHB, OP_LLB: begin
               o_aluOp  = w_op;
               o_sext   = {{(DATA_W-8){i_instr[7]}}, i_instr[7:0]};
               o_wrReg  = w_rd;
               w_wrCand = 1'b1;
               // LHB keeps the low byte of rd, so rd is also a source.
               if (w_op == OP_LHB) begin
                  o_rdReg1   = w_rd;
                  o_rdReg1En = 1'b1;
               end
            end
            OP_B: begin
               o_sext = {{(DATA_W-9){i_instr[8]}}, i_instr[8:0]};
            end
            OP_JAL: begin
               o_sext   = {{(DATA_W-12){i_instr[11]}}, i_instr[11:0]};
               o_wrReg  = 4'hF;
               w_wrCand = 1'b1;
            end
            OP_JR: begin
               o_rdReg1   = w_rs;
               o_rdReg1En = 1'b1;
            end
            default: ;
         endcase
      end

      o_wrRegEn = w_wrCand & (o_wrReg != 4'd0);
   end

   // Read ports: R0 and reset both yield zero.
   always_comb begin
      o_port0 = '0;
      o_port1 = '0;
      if (!i_rst) begin
         if (o_rdReg1 != 4'd0) o_port0 = r_regs[o_rdReg1];
         if (o_rdReg2 != 4'd0) o_port1 = r_regs[o_rdReg2];
`ifdef REG_BYPASS_EN
         if (w_wrQual && (o_rdReg1 == i_wrReg)) o_port0 = i_wrData;
         if (w_wrQual && (o_rdReg2 == i_wrReg)) o_port1 = i_wrData;
`endif
      end
   end

   // Register file; reset wins over a simultaneous write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_wrQual) begin
         r_regs[i_wrReg] <= i_wrData;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed cases followed by randomized vectors,
// all compared against a behavioural decode/register-file model.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst, hlt, wrEn, Z;
   logic [15:0] instr, pc, wrData;
   logic [3:0]  wrReg;
   logic [15:0] port0, port1, sext, instr_o;
   logic [3:0]  wrReg_o, aluOp, shAmt, rdReg1, rdReg2;
   logic        memRd, memWr, mem2reg, sawBr, sawJ, aluSrc, hlt_o;
   logic        wrRegEn, rdReg1En, rdReg2En;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mregs [16];

   always #5 clk = ~clk;

   id_stage #(.DATA_W(16), .NREG(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_hlt(hlt), .i_instr(instr), .i_pc(pc),
      .i_wrReg(wrReg), .i_wrData(wrData), .i_wrEn(wrEn), .i_Z(Z),
      .o_port0(port0), .o_port1(port1), .o_sext(sext), .o_instr(instr_o),
      .o_wrReg(wrReg_o), .o_memRd(memRd), .o_memWr(memWr), .o_aluOp(aluOp),
      .o_mem2reg(mem2reg), .o_sawBr(sawBr), .o_sawJ(sawJ), .o_aluSrc(aluSrc),
      .o_shAmt(shAmt), .o_rdReg1(rdReg1), .o_rdReg2(rdReg2), .o_hlt(hlt_o),
      .o_wrRegEn(wrRegEn), .o_rdReg1En(rdReg1En), .o_rdReg2En(rdReg2En)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] sx(input logic [15:0] v, input int bits);
      logic [15:0] m;
      m = 16'hFFFF << bits;
      return v[bits-1] ? (v | m) : (v & ~m);
   endfunction

   function automatic logic [15:0] model_read(input logic [3:0] n);
      if (rst || n == 4'd0) return 16'h0;
`ifdef REG_BYPASS_EN
      if (wrEn && !hlt && wrReg != 4'd0 && n == wrReg) return wrData;
`endif
      return mregs[n];
   endfunction

   // Expected outputs derived from the instruction-set description.
   task automatic check_all();
      logic [3:0]  op, rd, rs, rt, e_r1, e_r2, e_wr, e_alu;
      logic        e_r1en, e_r2en, e_wren;
      logic [15:0] e_sext;
      op = instr[15:12]; rd = instr[11:8]; rs = instr[7:4]; rt = instr[3:0];
      e_alu  = (op <= 4'd7 || op == 4'hA || op == 4'hB) ? op : 4'd0;
      case (op)
         4'h8, 4'h9: e_sext = sx(instr, 4);
         4'hA, 4'hB: e_sext = sx(instr, 8);
         4'hC:       e_sext = sx(instr, 9);
         4'hD:       e_sext = sx(instr, 12);
         default:    e_sext = 16'h0;
      endcase
      e_r1en = (op <= 4'h9) || op == 4'hE || op == 4'hA;
      e_r1   = (op == 4'hA) ? rd : (e_r1en ? rs : 4'd0);
      e_r2en = (op <= 4'd4) || op == 4'h9;
      e_r2   = (op == 4'h9) ? rd : (e_r2en ? rt : 4'd0);
      e_wr   = (op <= 4'h8 || op == 4'hA || op == 4'hB) ? rd :
               (op == 4'hD) ? 4'hF : 4'd0;
      e_wren = ((op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                            4'h8, 4'hA, 4'hB, 4'hD}) || (op == 4'h1 && Z))
               && e_wr != 4'd0;
      chk("port0",   port0,   model_read(e_r1));
      chk("port1",   port1,   model_read(e_r2));
      chk("sext",    sext,    e_sext);
      chk("instr",   instr_o, instr);
      chk("wrReg",   {12'h0, wrReg_o}, {12'h0, e_wr});
      chk("wrRegEn", {15'h0, wrRegEn}, {15'h0, e_wren});
      chk("aluOp",   {12'h0, aluOp},   {12'h0, e_alu});
      chk("aluSrc",  {15'h0, aluSrc},  {15'h0, op inside {4'h8, 4'h9, 4'hA, 4'hB}});
      chk("shAmt",   {12'h0, shAmt},   {12'h0, rt});
      chk("rdReg1",  {12'h0, rdReg1},  {12'h0, e_r1});
      chk("rdReg2",  {12'h0, rdReg2},  {12'h0, e_r2});
      chk("rd1En",   {15'h0, rdReg1En}, {15'h0, e_r1en});
      chk("rd2En",   {15'h0, rdReg2En}, {15'h0, e_r2en});
      chk("memRd",   {15'h0, memRd},   {15'h0, op == 4'h8});
      chk("memWr",   {15'h0, memWr},   {15'h0, op == 4'h9});
      chk("mem2reg", {15'h0, mem2reg}, {15'h0, op == 4'h8});
      chk("sawBr",   {15'h0, sawBr},   {15'h0, op == 4'hC});
      chk("sawJ",    {15'h0, sawJ},    {15'h0, op == 4'hD || op == 4'hE});
      chk("hlt",     {15'h0, hlt_o},   {15'h0, op == 4'hF});
   endtask

   // Check at the falling edge, then advance the model across the rising edge.
   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
      end else if (wrEn && !hlt && wrReg != 4'd0) begin
         mregs[wrReg] = wrData;
      end
      #1;
   endtask

   task automatic set(input logic [15:0] ins, input logic we, input logic [3:0] wr,
                      input logic [15:0] wd);
      instr = ins; wrEn = we; wrReg = wr; wrData = wd;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
      rst = 1'b1; hlt = 1'b0; Z = 1'b0; pc = 16'h0;
      set(16'h0312, 1'b0, 4'd0, 16'h0);
      step();                                   // reset cycle
      rst = 1'b0;
      step();                                   // ADD R3,R1,R2 after reset
      chk("rst_port0", port0, 16'h0);

      set(16'h0312, 1'b1, 4'd5, 16'h1234);
      step();
      set(16'h952F, 1'b0, 4'd0, 16'h0);         // SW R5,R2,F
      #1;
      chk("sw_port1", port1, 16'h1234);
      chk("sw_sext", sext, 16'hFFFF);
      step();

      set(16'h1412, 1'b0, 4'd0, 16'h0);         // ADDZ R4,R1,R2
      Z = 1'b0; step();
      Z = 1'b1; step();
      Z = 1'b0;

      set(16'h0100, 1'b1, 4'd0, 16'hBEEF);      // write R0
      step();
      set(16'h0100, 1'b1, 4'd6, 16'h5555);
      step();
      hlt = 1'b1;
      set(16'h0160, 1'b1, 4'd6, 16'h7777);      // blocked by halt
      step();
      hlt = 1'b0;
      set(16'h0160, 1'b0, 4'd0, 16'h0);
      #1;
      chk("hlt_r6", port0, 16'h5555);
      step();

      set(16'hD800, 1'b0, 4'd0, 16'h0);         // JAL 0x800
      step();
      set(16'hC0FF, 1'b0, 4'd0, 16'h0);         // B 0x0FF
      step();

      set(16'h0170, 1'b1, 4'd7, 16'h1111);
      step();
      set(16'h0170, 1'b1, 4'd7, 16'h00AA);      // same-cycle write/read R7
      #1;
`ifdef REG_BYPASS_EN
      chk("byp_r7", port0, 16'h00AA);
`else
      chk("byp_r7", port0, 16'h1111);
`endif
      step();
      set(16'h0170, 1'b0, 4'd0, 16'h0);
      step();

      for (int n = 0; n < 300; n++) begin
         rst    = ($urandom_range(0, 31) == 0);
         hlt    = ($urandom_range(0, 7) == 0);
         Z      = $urandom_range(0, 1);
         pc     = 16'($urandom);
         set(16'($urandom), ($urandom_range(0, 1) == 1), 4'($urandom), 16'($urandom));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage, 16-bit pipelined CPU.
- Decodes the instruction word coming out of the IF/ID register into control signals, register specifiers, a sign-extended immediate and two register operands.
- Holds the 16x16 architectural register file, written from the WB stage.
- Sits between the IF/ID and ID/EX pipeline registers.

Parameters:
- DATA_W, 16, register/data width
- NREG, 16, number of architectural registers (R0 reads as zero)

Ports:
- i_clk input 1: clock; all state updates on rising edge.
- i_rst input 1: reset, synchronous, active-high.
- i_hlt input 1: processor halted; blocks register writes.
- i_instr input 16: instruction word.
- i_pc input 16: PC of the instruction.
- i_wrReg input 4: WB destination register.
- i_wrData input 16: WB write data.
- i_wrEn input 1: WB write enable.
- i_Z input 1: current zero flag from EX; conditions ADDZ.
- o_port0 output 16: operand read on port 0.
- o_port1 output 16: operand read on port 1.
- o_sext output 16: sign-extended immediate.
- o_instr output 16: i_instr passed through unchanged.
- o_wrReg output 4: destination register.
- o_memRd output 1: LW.
- o_memWr output 1: SW.
- o_aluOp output 4: ALU operation.
- o_mem2reg output 1: writeback selects memory data.
- o_sawBr output 1: B instruction.
- o_sawJ output 1: JAL or JR.
- o_aluSrc output 1: ALU B operand = o_sext.
- o_shAmt output 4: shift amount.
- o_rdReg1 output 4: port-0 register number.
- o_rdReg2 output 4: port-1 register number.
- o_hlt output 1: HLT instruction.
- o_wrRegEn output 1: instruction writes o_wrReg.
- o_rdReg1En output 1: port 0 is a real source (hazard unit).
- o_rdReg2En output 1: port 1 is a real source (hazard unit).

Behaviour:
- All outputs are combinational from i_instr and the register file; decode latency is 0 cycles.
- Instruction fields: op = [15:12], rd = [11:8], rs = [7:4], rt = [3:0].
- Opcodes:
  - 0 ADD, 1 ADDZ, 2 SUB, 3 AND, 4 NOR, 5 SLL, 6 SRL, 7 SRA
  - 8 LW, 9 SW, A LHB, B LLB, C B, D JAL, E JR, F HLT
- o_aluOp:
  - = op for op 0–7, A and B.
  - = 0 (ADD) for LW/SW.
  - = 0 otherwise.
- o_aluSrc = 1 for LW, SW, LHB, LLB.
- o_shAmt = [3:0] for all instructions.
- o_sext:
  - LW/SW: sext([3:0]).
  - LHB/LLB: sext([7:0]).
  - B: sext([8:0]).
  - JAL: sext([11:0]).
  - Otherwise 0.
- Port 0 reads:
  - rs for op 0–7, LW, SW, JR.
  - rd for LHB.
  - o_rdReg1En = 1 in exactly these cases.
- Port 1 reads:
  - rt for op 0–4.
  - rd for SW.
  - o_rdReg2En = 1 in exactly these cases.
- When a port's enable is 0, its register number is 0.
- o_wrReg:
  - rd for op 0–7, LW, LHB, LLB.
  - 4'hF for JAL.
  - 0 otherwise.
- o_wrRegEn:
  - 1 for op 0, 2–7, LW, LHB, LLB, JAL.
  - ADDZ: 1 only when i_Z = 1.
  - Forced 0 when o_wrReg = 0.
- o_memRd = LW; o_memWr = SW; o_mem2reg = LW.
- o_sawBr = B; o_sawJ = JAL or JR.
- o_hlt = HLT (op F).
- Register file:
  - Reading R0 returns 0.
  - At posedge, regs[i_wrReg] <= i_wrData when i_wrEn & ~i_hlt & (i_wrReg != 0).
- Reset: i_rst high at a posedge clears all registers to 0; reset has priority over a simultaneous write.
- Outputs remain decode-valid during reset; operands read 0.
- Unused opcode fields have no effect; no illegal-instruction handling.

Optional Feature:
- REG_BYPASS_EN defined: a read of the register being written in the same cycle (same number, write qualified as above) returns i_wrData combinationally.
- Undefined: the read returns the stored (old) value until after the edge.

Test Plan:
- Reset: assert i_rst 1 cycle, then decode ADD R3,R1,R2 -> o_port0 = o_port1 = 0, o_wrReg = 3, o_wrRegEn = 1, o_aluOp = 0.
- Write R5 = 16'h1234 via i_wrEn, next cycle decode SW R5,R2,4'hF -> o_port1 = 16'h1234, o_rdReg2 = 5, o_sext = 16'hFFFF, o_memWr = 1, o_aluSrc = 1.
- ADDZ R4,R1,R2 with i_Z = 0 -> o_wrRegEn = 0; with i_Z = 1 -> o_wrRegEn = 1.
- Write to R0 with data 16'hBEEF -> reading R0 returns 0; write with i_hlt = 1 to R6 -> R6 unchanged.
- JAL offset 12'h800 -> o_sext = 16'hF800, o_wrReg = 4'hF, o_sawJ = 1; B with [8:0] = 9'h0FF -> o_sext = 16'h00FF, o_sawBr = 1.
- Same-cycle write/read of R7 = 16'h00AA -> o_port0 = 16'h00AA with REG_BYPASS_EN; old value without it.
